// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch.
package stopwatch_pkg;
  typedef enum logic [2:0] {IDLE, RUN, PAUSE, PROG, EXPIRED} sw_state_e;

  localparam int unsigned STEP_SEC   = 1000;
  localparam int unsigned STEP_MIN   = 60000;
  localparam int unsigned MAX_MS_DEF = 359999999;
endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts while en, pulses tick on the last cycle of each period.
module ms_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  // tick is kept independent of clr so the FSM next-state logic can use it without a loop
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/lap_stopwatch.sv
// Up/down ms stopwatch with programming mode and expiry pulse.
// Define STOPWATCH_LAP_EN to build the circular lap buffer; otherwise lap outputs tie to 0.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int          TICK_DIV  = 100000,
  parameter int          CNT_W     = 32,
  parameter int unsigned MAX_MS    = MAX_MS_DEF,
  parameter int          LAP_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         startstop,
  input  logic                         lap,
  input  logic                         clear,
  input  logic                         inc,
  input  logic                         up,
  input  logic                         prog,
  input  logic                         min,
  input  logic [$clog2(LAP_DEPTH)-1:0] lap_idx,
  output logic [CNT_W-1:0]             t,
  output logic                         running,
  output logic                         zero,
  output logic [CNT_W-1:0]             lap_data,
  output logic [$clog2(LAP_DEPTH):0]   lap_count
);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(MAX_MS);

  sw_state_e      state, state_n;
  logic           tick, run_st, expire, clr_pre;
  logic [CNT_W:0] prog_sum;

  assign run_st  = (state == RUN);
  // a down tick at 1 (or at 0 after a mid-run direction change) ends the run
  assign expire  = run_st && tick && !up && (t <= CNT_W'(1));
  assign clr_pre = clear || (state_n == IDLE);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .en    (run_st),
    .clr   (clr_pre),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (prog) state_n = PROG;
               else if (startstop && (up || t != '0)) state_n = RUN;
      RUN:     if (expire) state_n = EXPIRED;
               else if (startstop) state_n = PAUSE;
      PAUSE:   if (startstop) state_n = RUN;
      PROG:    if (!prog) state_n = IDLE;
      EXPIRED: if (startstop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_comb begin
    running = 1'b0;
    if (state == RUN) running = 1'b1;
  end

  assign prog_sum = {1'b0, t} + (CNT_W+1)'(min ? STEP_MIN : STEP_SEC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t    <= '0;
      zero <= 1'b0;
    end else begin
      zero <= 1'b0;
      if (clear) t <= '0;
      else if (run_st && tick) begin
        if (up) begin
          if (t < T_MAX) t <= t + 1'b1;
        end else if (t != '0) begin
          t    <= t - 1'b1;
          zero <= (t == CNT_W'(1));
        end
      end else if (state == PROG && inc) begin
        t <= (prog_sum > {1'b0, T_MAX}) ? T_MAX : prog_sum[CNT_W-1:0];
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  localparam int IW = $clog2(LAP_DEPTH);

  logic [LAP_DEPTH-1:0][CNT_W-1:0] laps;
  logic [IW-1:0]                   wptr, rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      laps      <= '0;
      wptr      <= '0;
      lap_count <= '0;
    end else if (clear) begin
      laps      <= '0;
      wptr      <= '0;
      lap_count <= '0;
    end else if (run_st && lap) begin
      laps[wptr] <= t;
      wptr       <= wptr + 1'b1;
      if (lap_count != (IW+1)'(LAP_DEPTH)) lap_count <= lap_count + 1'b1;
    end
  end

  // index 0 is the most recent write; depth is a power of two so the pointer wraps itself
  assign rd       = wptr - 1'b1 - lap_idx;
  assign lap_data = ({1'b0, lap_idx} < lap_count) ? laps[rd] : '0;
`else
  logic unused_lap;
  assign unused_lap = ^{lap, lap_idx};
  assign lap_data   = '0;
  assign lap_count  = '0;
`endif
endmodule

// File: tb/tb_lap_stopwatch.sv
// Randomised + directed bench for lap_stopwatch against a cycle-level behavioural model.
// Lap expectations follow STOPWATCH_LAP_EN the same way the design does.
module tb_lap_stopwatch;
  localparam int TD = 4, DEPTH = 4, MAXMS = 150000, CW = 32;

  logic          clock = 1'b0, reset = 1'b1;
  logic          startstop = 1'b0, lap = 1'b0, clear = 1'b0, inc = 1'b0;
  logic          up = 1'b1, prog = 1'b0, min = 1'b0;
  logic [1:0]    lap_idx = '0;
  logic [CW-1:0] t, lap_data;
  logic          running, zero;
  logic [2:0]    lap_count;

  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  lap_stopwatch #(.TICK_DIV(TD), .CNT_W(CW), .MAX_MS(MAXMS), .LAP_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .startstop(startstop), .lap(lap), .clear(clear),
    .inc(inc), .up(up), .prog(prog), .min(min), .lap_idx(lap_idx), .t(t),
    .running(running), .zero(zero), .lap_data(lap_data), .lap_count(lap_count)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 run, 2 pause, 3 prog, 4 expired; phase = cycles into current ms
  int      m_st = 0, m_phase = 0;
  longint  m_t = 0;
  bit      m_zero = 0;
  longint  laps[$];

  task automatic model_step();
    bit     tk = (m_st == 1) && (m_phase == TD - 1);
    longint step = min ? 60000 : 1000;
    m_zero = 0;
    if (clear) begin
      m_st = 0; m_t = 0; m_phase = 0; laps.delete();
      return;
    end
    case (m_st)
      0: if (prog) m_st = 3; else if (startstop && (up || m_t != 0)) m_st = 1;
      1: begin
`ifdef STOPWATCH_LAP_EN
        if (lap) begin
          laps.push_front(m_t);
          if (laps.size() > DEPTH) void'(laps.pop_back());
        end
`endif
        m_phase = tk ? 0 : m_phase + 1;
        if (tk && !up && m_t <= 1) begin
          m_zero = (m_t == 1); m_t = 0; m_st = 4;
        end else begin
          if (tk) m_t = up ? ((m_t < MAXMS) ? m_t + 1 : MAXMS) : m_t - 1;
          if (startstop) m_st = 2;
        end
      end
      2: if (startstop) m_st = 1;
      3: begin
        if (inc) m_t = (m_t + step > MAXMS) ? MAXMS : m_t + step;
        if (!prog) m_st = 0;
      end
      4: if (startstop) m_st = 0;
      default: m_st = 0;
    endcase
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_st = 0; m_t = 0; m_phase = 0; m_zero = 0; laps.delete();
    end else model_step();
  end

  always @(negedge clock) begin
    longint exp_ld;
    int     exp_lc;
    exp_ld = 0;
    exp_lc = 0;
`ifdef STOPWATCH_LAP_EN
    exp_lc = laps.size();
    if (int'(lap_idx) < exp_lc) exp_ld = laps[lap_idx];
`endif
    chk("t", t, m_t);
    chk("running", running, m_st == 1);
    chk("zero", zero, m_zero);
    chk("lap_count", lap_count, exp_lc);
    chk("lap_data", lap_data, exp_ld);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask
  task automatic ss();   startstop = 1; cyc(1); startstop = 0; endtask
  task automatic clr();  clear = 1;     cyc(1); clear = 0;     endtask
  task automatic incp(); inc = 1;       cyc(1); inc = 0;       endtask

  initial begin
    int vals[5] = '{3, 7, 12, 20, 25};
    int e, zc, zi;
    cyc(2); reset = 0; cyc(1);
    chk("rst_t", t, 0); chk("rst_running", running, 0); chk("rst_lap_count", lap_count, 0);

    // count up 10 ms, then pause
    up = 1; ss(); cyc(40);
    chk("up_t10", t, 10); chk("up_running", running, 1);
    ss(); cyc(5);
    chk("pause_hold", t, 10); chk("pause_running", running, 0);

    // lap and startstop together at t=5
    clr(); ss(); cyc(20);
    lap = 1; startstop = 1; cyc(1); lap = 0; startstop = 0;
    chk("lapss_running", running, 0);
    lap_idx = 0; #1;
`ifdef STOPWATCH_LAP_EN
    chk("lapss_count", lap_count, 1); chk("lapss_data", lap_data, 5);
    lap_idx = 1; #1; chk("lapss_idx_oob", lap_data, 0);
`else
    chk("nolap_count", lap_count, 0); chk("nolap_data", lap_data, 0);
`endif

    // five laps into a four-entry buffer
    clr(); ss(); e = 0;
    foreach (vals[k]) begin
      cyc(4 * vals[k] - e); lap = 1; cyc(1); lap = 0; e = 4 * vals[k] + 1;
    end
`ifdef STOPWATCH_LAP_EN
    chk("laps_count", lap_count, 4);
    lap_idx = 0; #1; chk("lap_idx0", lap_data, 25);
    lap_idx = 1; #1; chk("lap_idx1", lap_data, 20);
    lap_idx = 2; #1; chk("lap_idx2", lap_data, 12);
    lap_idx = 3; #1; chk("lap_idx3", lap_data, 7);
`else
    chk("nolap_count2", lap_count, 0);
`endif
    lap_idx = 0;

    // programming and saturation
    clr(); up = 1; prog = 1; cyc(1); min = 1;
    incp(); incp(); chk("prog_120000", t, 120000);
    incp(); chk("prog_sat", t, MAXMS);
    prog = 0; cyc(1); ss(); cyc(20);
    chk("up_sat", t, MAXMS); chk("up_sat_running", running, 1);

    // count down from 120000
    clr(); prog = 1; cyc(1); incp(); incp(); prog = 0; cyc(1);
    up = 0; ss(); cyc(40); chk("down_119990", t, 119990);

    // expiry from 2000 ms: exactly one zero pulse 8000 cycles after start
    clr(); min = 0; prog = 1; cyc(1); incp(); incp(); chk("prog_2000", t, 2000);
    prog = 0; cyc(1); ss();
    zc = 0; zi = -1;
    for (int i = 0; i < 8100; i++) begin
      cyc(1);
      if (zero) begin zc++; zi = i; end
    end
    chk("zero_pulses", zc, 1); chk("zero_cycle", zi, 7999);
    chk("expired_t", t, 0); chk("expired_running", running, 0);
    prog = 1; incp(); chk("expired_ignores_inc", t, 0);
    prog = 0; ss(); ss(); cyc(3);
    chk("idle_down_zero_no_start", running, 0);
    prog = 1; cyc(1); incp(); chk("prog_after_expiry", t, 1000);

    // clear from PROG lands in IDLE
    clear = 1; prog = 0; cyc(1); clear = 0;
    chk("clear_prog_t", t, 0);
    incp(); chk("idle_ignores_inc", t, 0); chk("clear_prog_running", running, 0);

    // reset mid-run at t=9
    up = 1; ss(); cyc(36); chk("pre_reset_t9", t, 9);
    reset = 1; #1;
    chk("reset_t", t, 0); chk("reset_running", running, 0); chk("reset_zero", zero, 0);
    chk("reset_lap_count", lap_count, 0); chk("reset_lap_data", lap_data, 0);
    cyc(2); reset = 0; cyc(2); chk("post_reset_t", t, 0);

    // randomised traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      startstop = ($urandom_range(0, 19) == 0);
      lap       = ($urandom_range(0, 3) == 0);
      clear     = ($urandom_range(0, 299) == 0);
      inc       = ($urandom_range(0, 2) == 0);
      min       = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) prog = ~prog;
      if ($urandom_range(0, 99) == 0) up = ~up;
      lap_idx   = 2'($urandom_range(0, 3));
      cyc(1);
    end
    startstop = 0; lap = 0; clear = 0; inc = 0; prog = 0;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
